// File: rtl/otter_iobus_timer_if.sv
// IOBUS signal bundle between the MCU (master) and a memory-mapped peripheral (slave).
interface otter_iobus_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/otter_iobus_timer.sv
// Memory-mapped prescaled timer with compare match, overrun status and a level interrupt
// for the OTTER IOBUS. Read data is combinational and zero outside the register window.
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          PRESC_W   = 16,
  parameter int          CNT_W     = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  otter_iobus_timer_if.slave  bus,
  output logic                INTR
);

  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_PRESC  = 3'd1;
  localparam logic [2:0] SEL_CMP    = 3'd2;
  localparam logic [2:0] SEL_COUNT  = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;

  logic               en;
  logic               auto_reload;
  logic               irq_en;
  logic [PRESC_W-1:0] prescale;
  logic [PRESC_W-1:0] pcnt;
  logic [CNT_W-1:0]   compare;
  logic [CNT_W-1:0]   count;
  logic               pend;
  logic               ovr;

  logic        hit;
  logic [2:0]  sel;
  logic        wr_ctrl;
  logic        wr_presc;
  logic        wr_cmp;
  logic        wr_count;
  logic        wr_status;
  logic        tick;
  logic        match;
  logic        clr_pend;
  logic        clr_ovr;
  logic        set_ovr;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit       = (bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign sel       = bus.IOBUS_ADDR[4:2];
  assign wr_ctrl   = bus.IOBUS_WR && hit && (sel == SEL_CTRL);
  assign wr_presc  = bus.IOBUS_WR && hit && (sel == SEL_PRESC);
  assign wr_cmp    = bus.IOBUS_WR && hit && (sel == SEL_CMP);
  assign wr_count  = bus.IOBUS_WR && hit && (sel == SEL_COUNT);
  assign wr_status = bus.IOBUS_WR && hit && (sel == SEL_STATUS);

  // A CPU write to COUNT on a tick cycle suppresses both the increment and the match.
  assign tick     = en && (pcnt == prescale);
  assign match    = tick && !wr_count && (count == compare);
  assign clr_pend = wr_status && bus.IOBUS_OUT[0];
  assign clr_ovr  = wr_status && bus.IOBUS_OUT[1];
  assign set_ovr  = match && pend && !clr_pend;

  assign unused_bits = ^{bus.IOBUS_ADDR[1:0], bus.IOBUS_OUT};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pcnt <= '0;
    end else if (!en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // CPU writes to CTRL take precedence over the one-shot disable.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
    end else if (wr_ctrl) begin
      en          <= bus.IOBUS_OUT[0];
      auto_reload <= bus.IOBUS_OUT[1];
      irq_en      <= bus.IOBUS_OUT[2];
    end else if (match && !auto_reload) begin
      en <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (wr_presc) prescale <= bus.IOBUS_OUT[PRESC_W-1:0];
      if (wr_cmp)   compare  <= bus.IOBUS_OUT[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (wr_count) begin
      count <= bus.IOBUS_OUT[CNT_W-1:0];
    end else if (match) begin
      if (auto_reload) count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

  // Setting a status bit wins over clearing it in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (match)         pend <= 1'b1;
      else if (clr_pend) pend <= 1'b0;
      if (set_ovr)       ovr  <= 1'b1;
      else if (clr_ovr)  ovr  <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        SEL_CTRL:   rdata[2:0]         = {irq_en, auto_reload, en};
        SEL_PRESC:  rdata[PRESC_W-1:0] = prescale;
        SEL_CMP:    rdata[CNT_W-1:0]   = compare;
        SEL_COUNT:  rdata[CNT_W-1:0]   = count;
        SEL_STATUS: rdata[1:0]         = {ovr, pend};
        default:    rdata              = '0;
      endcase
    end
  end

  assign bus.IOBUS_IN = rdata;
  assign INTR         = pend && irq_en;

endmodule
